// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the cascaded modulo counter.
// Direction encodings and load-value clamping live here.
package cnt_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Any value outside the digit's range saturates to the largest legal digit.
  function automatic int unsigned clamp_digit(int unsigned value, int unsigned base);
    return (value >= base) ? base - 1 : value;
  endfunction

endpackage

// File: rtl/cnt_digit.sv
// One modulo-BASE digit with step, direction, clear and clamped load.
// Wraps between 0 and BASE-1 in both directions; never leaves that range.
module cnt_digit
  import cnt_pkg::*;
#(
  parameter int unsigned BASE = 10,
  parameter int unsigned DW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          up_dn,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  output logic [DW-1:0] q,
  output logic          at_max,
  output logic          at_zero
);

  localparam logic [DW-1:0] MaxVal = DW'(BASE - 1);

  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;
  logic [DW-1:0] ld_clamped;

  assign ld_clamped = DW'(clamp_digit(32'(ld_val), BASE));

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = ld_clamped;
    end else if (step) begin
      if (up_dn == CNT_UP) begin
        q_d = (q_q == MaxVal) ? '0 : q_q + 1'b1;
      end else begin
        q_d = (q_q == '0) ? MaxVal : q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign at_max  = (q_q == MaxVal);
  assign at_zero = (q_q == '0);

endmodule

// File: rtl/cnt_mod_chain.sv
// Cascaded modulo-BASE up/down counter with arming, load/clear and cascade carry.
// Digits ripple-enable each other; the chain carry also feeds a registered wrap pulse.
module cnt_mod_chain
  import cnt_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BASE   = 10,
  parameter int unsigned DW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 up_dn,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  input  logic                 clr,
  output logic [DIGITS*DW-1:0] cnt,
  output logic                 active,
  output logic                 carry_out,
  output logic                 wrap
);

  logic              active_q;
  logic              active_d;
  logic              wrap_q;
  logic              wrap_d;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] step;
  logic [DIGITS:0]   lower_term;

  assign lower_term[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    // Terminal value depends on direction: BASE-1 going up, 0 going down.
    assign term[i]         = (up_dn == CNT_UP) ? at_max[i] : at_zero[i];
    assign lower_term[i+1] = lower_term[i] & term[i];
    assign step[i]         = en & active_q & lower_term[i];

    cnt_digit #(
      .BASE (BASE),
      .DW   (DW)
    ) u_digit (
      .clk     (clk),
      .reset   (reset),
      .step    (step[i]),
      .up_dn   (up_dn),
      .clr     (clr),
      .load    (load),
      .ld_val  (load_val[i*DW +: DW]),
      .q       (cnt[i*DW +: DW]),
      .at_max  (at_max[i]),
      .at_zero (at_zero[i])
    );
  end

  assign carry_out = en & active_q & lower_term[DIGITS];

  always_comb begin
    // The first enable after reset only arms the chain; clr/load arm it too.
    active_d = active_q | en | clr | load;
    wrap_d   = carry_out & ~clr & ~load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      wrap_q   <= wrap_d;
    end
  end

  assign active = active_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_cnt_mod_chain.sv
// Directed, table-driven bench for cnt_mod_chain (2 decimal digits), plus full
// up/down sweeps checked against an integer model.
module tb_cnt_mod_chain;
  import cnt_pkg::*;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load, clr;
  logic [7:0] load_val;
  logic [7:0] cnt;
  logic       active, carry_out, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  cnt_mod_chain #(
    .DIGITS (2),
    .BASE   (10),
    .DW     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .clr       (clr),
    .cnt       (cnt),
    .active    (active),
    .carry_out (carry_out),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ud;
    logic       ld;
    logic [7:0] lv;
    logic       clr;
    logic       chk_c;
    logic       exp_c;
    logic [7:0] exp_cnt;
    logic       exp_act;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic e, input logic ud, input logic ld,
                     input logic [7:0] lv, input logic c, input logic chk_c,
                     input logic exp_c, input logic [7:0] exp_cnt, input logic exp_act,
                     input logic exp_wrap);
    vec_t v;
    v.rst = rst; v.en = e; v.ud = ud; v.ld = ld; v.lv = lv; v.clr = c;
    v.chk_c = chk_c; v.exp_c = exp_c; v.exp_cnt = exp_cnt;
    v.exp_act = exp_act; v.exp_wrap = exp_wrap;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic e, input logic ud, input logic ld,
                       input logic [7:0] lv, input logic c);
    reset = rst; en = e; up_dn = ud; load = ld; load_val = lv; clr = c;
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  initial begin
    int val;
    int wraps;
    logic exp_c;

    drive(1'b0, 1'b0, CNT_UP, 1'b0, 8'h00, 1'b0);

    // rst en ud ld lv clr | chk_c exp_c cnt act wrap
    // Reset then arm, then two up steps
    add(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    add(1, 0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    add(0, 1, 1, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0);
    add(0, 1, 1, 0, 8'h00, 0, 1, 0, 8'h01, 1, 0);
    add(0, 1, 1, 0, 8'h00, 0, 1, 0, 8'h02, 1, 0);
    // Load 98 and wrap upward
    add(0, 0, 1, 1, 8'h98, 0, 1, 0, 8'h98, 1, 0);
    add(0, 1, 1, 0, 8'h00, 0, 1, 0, 8'h99, 1, 0);
    add(0, 1, 1, 0, 8'h00, 0, 1, 1, 8'h00, 1, 1);
    add(0, 0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0);
    // Load 00 and wrap downward
    add(0, 0, 0, 1, 8'h00, 0, 1, 0, 8'h00, 1, 0);
    add(0, 1, 0, 0, 8'h00, 0, 1, 1, 8'h99, 1, 1);
    add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h99, 1, 0);
    // Clamped loads
    add(0, 0, 1, 1, 8'h0F, 0, 1, 0, 8'h09, 1, 0);
    add(0, 0, 1, 1, 8'hC3, 0, 1, 0, 8'h93, 1, 0);
    // Load over a terminal enabled step: carry high, wrap suppressed
    add(0, 0, 1, 1, 8'h99, 0, 1, 0, 8'h99, 1, 0);
    add(0, 1, 1, 1, 8'h05, 0, 1, 1, 8'h05, 1, 0);
    // Priority clr > load > en, then hold
    add(0, 0, 1, 1, 8'h45, 0, 1, 0, 8'h45, 1, 0);
    add(0, 1, 1, 1, 8'h12, 1, 1, 0, 8'h00, 1, 0);
    add(0, 1, 1, 1, 8'h12, 0, 1, 0, 8'h12, 1, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 0, 8'h12, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h12, 1, 0);
    add(0, 0, 1, 0, 8'h00, 0, 1, 0, 8'h12, 1, 0);
    // Clear over a terminal enabled step: wrap suppressed
    add(0, 0, 1, 1, 8'h99, 0, 1, 0, 8'h99, 1, 0);
    add(0, 1, 1, 0, 8'h00, 1, 1, 1, 8'h00, 1, 0);
    // Reset mid-count overrides load, then re-arm
    add(0, 0, 1, 1, 8'h35, 0, 1, 0, 8'h35, 1, 0);
    add(0, 1, 1, 0, 8'h00, 0, 1, 0, 8'h36, 1, 0);
    add(0, 1, 1, 0, 8'h00, 0, 1, 0, 8'h37, 1, 0);
    add(1, 1, 1, 1, 8'h55, 0, 1, 0, 8'h00, 0, 0);
    add(0, 1, 1, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0);
    add(0, 1, 1, 0, 8'h00, 0, 1, 0, 8'h01, 1, 0);
    // Clear arms from idle; idle arming down does not step
    add(1, 0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    add(0, 0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].ud, vecs[i].ld, vecs[i].lv, vecs[i].clr);
      #1;
      if (vecs[i].chk_c) check("carry_out", i, {7'd0, carry_out}, {7'd0, vecs[i].exp_c});
      @(posedge clk);
      #1;
      check("cnt", i, cnt, vecs[i].exp_cnt);
      check("active", i, {7'd0, active}, {7'd0, vecs[i].exp_act});
      check("wrap", i, {7'd0, wrap}, {7'd0, vecs[i].exp_wrap});
      @(negedge clk);
    end

    // Full upward sweep from 00: exactly one wrap per 100 steps
    drive(0, 0, CNT_UP, 1, 8'h00, 0);
    @(negedge clk);
    val   = 0;
    wraps = 0;
    for (int k = 0; k < 100; k++) begin
      drive(0, 1, CNT_UP, 0, 8'h00, 0);
      #1;
      exp_c = (val == 99);
      check("sweep_up_carry", k, {7'd0, carry_out}, {7'd0, exp_c});
      @(posedge clk);
      #1;
      val = (val + 1) % 100;
      check("sweep_up_cnt", k, cnt, bcd(val));
      check("sweep_up_wrap", k, {7'd0, wrap}, {7'd0, exp_c});
      if (wrap === 1'b1) wraps++;
      @(negedge clk);
    end
    check("sweep_up_wraps", 0, 8'(wraps), 8'd1);

    // Full downward sweep from 00
    wraps = 0;
    for (int k = 0; k < 100; k++) begin
      drive(0, 1, CNT_DN, 0, 8'h00, 0);
      #1;
      exp_c = (val == 0);
      check("sweep_dn_carry", k, {7'd0, carry_out}, {7'd0, exp_c});
      @(posedge clk);
      #1;
      val = (val + 99) % 100;
      check("sweep_dn_cnt", k, cnt, bcd(val));
      check("sweep_dn_wrap", k, {7'd0, wrap}, {7'd0, exp_c});
      if (wrap === 1'b1) wraps++;
      @(negedge clk);
    end
    check("sweep_dn_wraps", 0, 8'(wraps), 8'd1);

    drive(0, 0, CNT_UP, 0, 8'h00, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
